// File: rtl/hps_ext_sched_pkg.sv
// hps_ext_pkg: shared types and helpers for the HPS extension-channel scheduler.
//   state_t       : scheduler FSM states
//   DONE_PAGE_DEF : default ext_addr[15:8] page whose write retires a grant
//   EXT_REQ_VALID : bit of ext_req that marks the advertised index as valid
//   rr_pick()     : round-robin first-set finder over an 8-bit request vector
package hps_ext_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    ACTIVE  = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam logic [7:0] DONE_PAGE_DEF = 8'hFE;
  localparam int         EXT_REQ_VALID = 7;

  // First set bit of req at or after ptr, wrapping at 8. Request bits at or
  // above the real device count are always zero, so wrapping at 8 gives the
  // same order as wrapping at the device count. Returns ptr when req is empty.
  function automatic logic [2:0] rr_pick(input logic [7:0] req, input logic [2:0] ptr);
    logic [2:0] k;
    logic       found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int i = 0; i < 8; i++) begin
      k = ptr + 3'(i);
      if (!found && req[k]) begin
        rr_pick = k;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/hps_ext_sched_if.sv
// hps_ext_if: HPS side of the extension transfer channel.
//   addr[15:8] page (device index or done page), addr[7:0] offset
//   rd / wr    one-cycle access strobes from the HPS
//   dout       HPS write data,  din  read data back to the HPS
//   req        {valid, 4'b0, idx[2:0]} advertising the granted device
// Handshake: devices hold a level request until the scheduler pulses their
// ack (or drop it to cancel); the HPS learns the granted device from req and
// retires it by writing the device index to the done page.
// Modports: master = HPS (drives addr/rd/wr/dout), slave = scheduler.
interface hps_ext_if;
  logic [15:0] addr;
  logic        rd;
  logic        wr;
  logic [15:0] dout;
  logic [15:0] din;
  logic [7:0]  req;

  modport master (output addr, rd, wr, dout, input din, req);
  modport slave  (input addr, rd, wr, dout, output din, req);
endinterface

// File: rtl/hps_ext_sched_rr_arbiter.sv
// rr_arbiter: round-robin first-set finder with its own pointer register.
//   clk_sys, reset_n : clock, synchronous active-low reset (pointer -> 0)
//   req              : per-device level requests
//   load, last       : on load, pointer moves to last+1 (wrapping at NREQ)
//   pick             : first requester at or after the pointer
//   any              : at least one request pending
module rr_arbiter
  import hps_ext_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic            clk_sys,
  input  logic            reset_n,
  input  logic [NREQ-1:0] req,
  input  logic            load,
  input  logic [2:0]      last,
  output logic [2:0]      pick,
  output logic            any
);

  logic [2:0] ptr;
  logic [7:0] req8;

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      ptr <= 3'd0;
    end else if (load) begin
      ptr <= (last == 3'(NREQ - 1)) ? 3'd0 : last + 3'd1;
    end
  end

  always_comb begin
    req8             = '0;
    req8[NREQ-1:0]   = req;
    pick             = rr_pick(req8, ptr);
    any              = |req;
  end

endmodule

// File: rtl/hps_ext_sched.sv
// hps_ext_sched: shares the HPS extension channel between up to 8 devices.
// Grants round-robin, advertises the grant on ext.req, routes HPS accesses on
// the granted device's page to that device only, and retires the grant on a
// done-page write carrying the device index (or on cancel / timeout).
// Ports:
//   clk_sys, reset_n    clock, synchronous active-low reset
//   dev_req/ack/err/gnt per-device request, ack pulse, timeout-error pulse, grant
//   dev_addr/wdata      ext.addr[7:0] / ext.dout passthrough
//   dev_rd/dev_wr       HPS strobes gated to the granted device
//   dev_rdata           per-device read data, device i at [16i+15:16i]
//   ext                 HPS channel (hps_ext_if.slave)
//   dbg_state           current FSM state
// Build option: define HPS_SCHED_TIMEOUT_EN to add the inactivity timeout
// (TMO_W-bit counter); without it dev_err stays 0 and grants never time out.
module hps_ext_sched
  import hps_ext_pkg::*;
#(
  parameter int         NREQ      = 4,
  parameter logic [7:0] DONE_PAGE = DONE_PAGE_DEF,
  parameter int         TMO_W     = 24
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  input  logic [NREQ-1:0]  dev_req,
  output logic [NREQ-1:0]  dev_ack,
  output logic             dev_err,
  output logic [NREQ-1:0]  dev_gnt,
  output logic [7:0]       dev_addr,
  output logic [15:0]      dev_wdata,
  output logic             dev_rd,
  output logic             dev_wr,
  input  logic [NREQ*16-1:0] dev_rdata,
  hps_ext_if.slave         ext,
  output state_t           dbg_state
);

  state_t       state, state_nxt;
  logic [2:0]   idx;
  logic [2:0]   pick;
  logic         req_any;
  logic         ack_q, ack_nxt;
  logic         err_q, err_nxt;
  logic         active, page_hit, done, cancel, tmo_exp;
  logic [7:0]   req8;
  logic [127:0] rdata8;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .req     (dev_req),
    .load    (state == RELEASE),
    .last    (idx),
    .pick    (pick),
    .any     (req_any)
  );

  // Zero-padded copies so a 3-bit index selects without range issues.
  always_comb begin
    req8               = '0;
    req8[NREQ-1:0]     = dev_req;
    rdata8             = '0;
    rdata8[NREQ*16-1:0] = dev_rdata;
  end

  assign active   = (state == ACTIVE);
  assign page_hit = (ext.addr[15:8] == {5'b00000, idx});
  assign done     = active & ext.wr & (ext.addr[15:8] == DONE_PAGE) & (ext.dout[2:0] == idx);
  assign cancel   = active & ~req8[idx];

  // State register. The pick is captured on the IDLE->GRANT edge so idx is
  // stable for the whole GRANT cycle and the grant that follows.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state <= IDLE;
      idx   <= 3'd0;
      ack_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      ack_q <= ack_nxt;
      err_q <= err_nxt;
      if (state == IDLE && req_any) idx <= pick;
    end
  end

  // Next state. Done outranks cancel and timeout in the same cycle.
  always_comb begin
    state_nxt = state;
    ack_nxt   = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      IDLE:    if (req_any) state_nxt = GRANT;
      GRANT:   state_nxt = ACTIVE;
      ACTIVE: begin
        if (done) begin
          state_nxt = RELEASE;
          ack_nxt   = 1'b1;
        end else if (cancel) begin
          state_nxt = RELEASE;
        end else if (tmo_exp) begin
          state_nxt = RELEASE;
          ack_nxt   = 1'b1;
          err_nxt   = 1'b1;
        end
      end
      RELEASE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs and routing.
  always_comb begin
    ext.req = 8'h00;
    if (active) begin
      ext.req[2:0]           = idx;
      ext.req[EXT_REQ_VALID] = 1'b1;
    end
    dev_gnt   = active ? (NREQ'(1) << idx) : '0;
    dev_ack   = ack_q  ? (NREQ'(1) << idx) : '0;
    dev_err   = err_q;
    dev_addr  = ext.addr[7:0];
    dev_wdata = ext.dout;
    dev_rd    = ext.rd & active & page_hit;
    dev_wr    = ext.wr & active & page_hit;
    ext.din   = (active & page_hit) ? rdata8[{idx, 4'b0000} +: 16] : 16'h0000;
    dbg_state = state;
  end

`ifdef HPS_SCHED_TIMEOUT_EN
  localparam logic [TMO_W-1:0] TMO_LAST = ~(TMO_W'(1));

  logic [TMO_W-1:0] tmo;
  logic             routed;

  assign routed = dev_rd | dev_wr;

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      tmo <= '0;
    end else if (state == GRANT) begin
      tmo <= '0;
    end else if (active) begin
      tmo <= routed ? '0 : tmo + TMO_W'(1);
    end
  end

  // The counter reaches all-ones at the end of this cycle: the grant expires
  // now, so the ack/err pulse lands right after the last counted cycle.
  assign tmo_exp = active & ~routed & (tmo == TMO_LAST);
`else
  assign tmo_exp = 1'b0;
`endif

endmodule

// File: tb/tb_hps_ext_sched.sv
// tb_hps_ext_sched: directed bench for hps_ext_sched (NREQ=4, TMO_W=4).
// Grants expected from the round-robin order are queued in exp_q when the
// request is driven and popped when ext_req turns valid.
module tb_hps_ext_sched;
  import hps_ext_pkg::*;

  logic        clk;
  logic        reset_n;
  logic [3:0]  dev_req;
  logic [3:0]  dev_ack;
  logic        dev_err;
  logic [3:0]  dev_gnt;
  logic [7:0]  dev_addr;
  logic [15:0] dev_wdata;
  logic        dev_rd;
  logic        dev_wr;
  logic [63:0] dev_rdata;
  state_t      dbg_state;

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_q[$];

  hps_ext_if ext ();

  hps_ext_sched #(.NREQ(4), .DONE_PAGE(8'hFE), .TMO_W(4)) dut (
    .clk_sys   (clk),
    .reset_n   (reset_n),
    .dev_req   (dev_req),
    .dev_ack   (dev_ack),
    .dev_err   (dev_err),
    .dev_gnt   (dev_gnt),
    .dev_addr  (dev_addr),
    .dev_wdata (dev_wdata),
    .dev_rd    (dev_rd),
    .dev_wr    (dev_wr),
    .dev_rdata (dev_rdata),
    .ext       (ext.slave),
    .dbg_state (dbg_state)
  );

  // Clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Driver and checking tasks
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic hps_write(input logic [15:0] a, input logic [15:0] d);
    ext.addr = a;
    ext.dout = d;
    ext.wr   = 1'b1;
    cyc();
    ext.wr   = 1'b0;
    ext.addr = 16'h0000;
  endtask

  // Waits (bounded) for a valid grant, then compares it against the queue head.
  task automatic wait_grant(input string tag, output logic [7:0] e);
    logic [3:0] g;
    int n;
    n = 0;
    while (ext.req[7] !== 1'b1 && n < 10) begin
      cyc();
      n++;
    end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hFF;
    g = 4'b0001 << e[2:0];
    check(tag, ext.req, e);
    check({tag, "_gnt"}, dev_gnt, g);
  endtask

  // Directed sequence
  initial begin
    logic [7:0] e;
    logic [3:0] g;
    reset_n   = 1'b0;
    dev_req   = 4'b0000;
    dev_rdata = {16'hA003, 16'hA002, 16'hBEEF, 16'hA000};
    ext.addr  = 16'h0000;
    ext.rd    = 1'b0;
    ext.wr    = 1'b0;
    ext.dout  = 16'h0000;
    repeat (3) cyc();

    check("rst_ext_req", ext.req, 8'h00);
    check("rst_gnt", dev_gnt, 4'b0000);
    check("rst_ack", dev_ack, 4'b0000);
    check("rst_err", dev_err, 1'b0);
    check("rst_state", dbg_state, IDLE);
    reset_n = 1'b1;
    cyc();

    // Round-robin from pointer 0 with 1011 held: 0,1,3,0
    dev_req = 4'b1011;
    exp_q.push_back(8'h80);
    exp_q.push_back(8'h81);
    exp_q.push_back(8'h83);
    exp_q.push_back(8'h80);
    for (int i = 0; i < 4; i++) begin
      wait_grant("rr_grant", e);
      hps_write(16'hFE00, {13'b0, e[2:0]});
      g = 4'b0001 << e[2:0];
      check("rr_ack", dev_ack, g);
      check("rr_gap", ext.req, 8'h00);
      if (i == 3) dev_req = 4'b0000;
    end
    cyc();

    // Single request: ext_req valid exactly two clocks after dev_req
    dev_req = 4'b0100;
    exp_q.push_back(8'h82);
    cyc();
    check("lat_first_clk", ext.req, 8'h00);
    cyc();
    e = exp_q.pop_front();
    check("lat_grant", ext.req, e);
    check("lat_gnt", dev_gnt, 4'b0100);
    hps_write(16'hFE00, 16'h0002);
    check("single_ack", dev_ack, 4'b0100);
    check("single_release_req", ext.req, 8'h00);
    check("single_release_gnt", dev_gnt, 4'b0000);
    dev_req = 4'b0000;
    cyc();
    check("single_ack_once", dev_ack, 4'b0000);
    check("single_idle", dbg_state, IDLE);

    // Routing on grant idx 1
    dev_req = 4'b0010;
    exp_q.push_back(8'h81);
    wait_grant("route_grant", e);
    ext.addr = 16'h0105;
    ext.rd   = 1'b1;
    #1;
    check("route_din", ext.din, 16'hBEEF);
    check("route_rd", dev_rd, 1'b1);
    check("route_addr", dev_addr, 8'h05);
    ext.addr = 16'h0205;
    #1;
    check("route_other_din", ext.din, 16'h0000);
    check("route_other_rd", dev_rd, 1'b0);
    ext.rd   = 1'b0;
    ext.addr = 16'h0005;
    ext.dout = 16'h1234;
    ext.wr   = 1'b1;
    #1;
    check("route_other_wr", dev_wr, 1'b0);
    check("route_wdata", dev_wdata, 16'h1234);
    ext.addr = 16'h0105;
    #1;
    check("route_own_wr", dev_wr, 1'b1);
    ext.wr   = 1'b0;
    ext.addr = 16'h0000;
    cyc();

    // Wrong-index done is ignored, then cancel by dropping the request
    hps_write(16'hFE00, 16'h0003);
    check("wrong_done_kept", ext.req, 8'h81);
    check("wrong_done_no_ack", dev_ack, 4'b0000);
    dev_req = 4'b0000;
    cyc();
    check("cancel_req", ext.req, 8'h00);
    check("cancel_no_ack", dev_ack, 4'b0000);
    check("cancel_no_err", dev_err, 1'b0);
    cyc();

`ifdef HPS_SCHED_TIMEOUT_EN
    // Plain expiry after 15 ACTIVE cycles
    dev_req = 4'b0001;
    exp_q.push_back(8'h80);
    wait_grant("tmo_grant", e);
    repeat (14) cyc();
    check("tmo_still_active", dbg_state, ACTIVE);
    check("tmo_no_ack_yet", dev_ack, 4'b0000);
    cyc();
    check("tmo_ack", dev_ack, 4'b0001);
    check("tmo_err", dev_err, 1'b1);

    // A routed read at ACTIVE cycle 10 restarts the count
    exp_q.push_back(8'h80);
    wait_grant("tmo_restart_grant", e);
    repeat (9) cyc();
    ext.addr = 16'h0000;
    ext.rd   = 1'b1;
    #1;
    check("tmo_read_routed", dev_rd, 1'b1);
    cyc();
    ext.rd = 1'b0;
    repeat (14) cyc();
    check("tmo_restart_active", dbg_state, ACTIVE);
    check("tmo_restart_no_ack", dev_ack, 4'b0000);
    cyc();
    check("tmo_restart_ack", dev_ack, 4'b0001);
    check("tmo_restart_err", dev_err, 1'b1);

    // Done on the expiry cycle wins
    exp_q.push_back(8'h80);
    wait_grant("tmo_done_grant", e);
    repeat (14) cyc();
    hps_write(16'hFE00, 16'h0000);
    check("tmo_done_ack", dev_ack, 4'b0001);
    check("tmo_done_no_err", dev_err, 1'b0);
    dev_req = 4'b0000;
    cyc();
`else
    // Without the timeout a grant persists until done
    dev_req = 4'b0001;
    exp_q.push_back(8'h80);
    wait_grant("hold_grant", e);
    repeat (40) cyc();
    check("hold_req", ext.req, 8'h80);
    check("hold_no_err", dev_err, 1'b0);
    hps_write(16'hFE00, 16'h0000);
    check("hold_ack", dev_ack, 4'b0001);
    check("hold_done_no_err", dev_err, 1'b0);
    dev_req = 4'b0000;
    cyc();
`endif

    // Reset during ACTIVE drops the grant without an ack
    dev_req = 4'b1000;
    exp_q.push_back(8'h83);
    wait_grant("rst_mid_grant", e);
    reset_n = 1'b0;
    cyc();
    check("rst_mid_req", ext.req, 8'h00);
    check("rst_mid_gnt", dev_gnt, 4'b0000);
    check("rst_mid_ack", dev_ack, 4'b0000);
    check("rst_mid_err", dev_err, 1'b0);
    check("rst_mid_state", dbg_state, IDLE);
    dev_req = 4'b0001;
    reset_n = 1'b1;
    exp_q.push_back(8'h80);
    wait_grant("rst_fresh_grant", e);
    hps_write(16'hFE00, 16'h0000);
    check("rst_fresh_ack", dev_ack, 4'b0001);
    dev_req = 4'b0000;
    cyc();

    // Final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
